hex_display_scanner: RTL and testbench
======================================

# hex_display_scanner

Time-multiplexing scanner for a common-anode multi-digit seven-segment display, sitting directly upstream of the board's hex seven-segment decoder. It accepts a packed hex word and double-buffers it so a frame is never torn. It cycles through the digits at a programmable refresh rate and presents one 4-bit nibble at a time, plus a per-digit blank flag and active-low digit enables. Typical use: showing the byte/word currently handled by the UART transmitter.

## Interface
- NUM_DIGITS, 4: number of display digits (2–8).
- REFRESH_DIV, 50000: clock cycles each digit stays lit (≥2).
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures data_in into the shadow register.
- data_in  in  4*NUM_DIGITS  packed hex value; nibble k (bits 4k+3:4k) is digit k, digit 0 rightmost.
- blank_lz  in  1  1 = suppress leading zeros.
- digit_nibble  out  4  nibble for the active digit, to the decoder input.
- digit_blank  out  1  1 = active digit blanked; top level forces segments to 7'b1111111.
- anode_n  out  NUM_DIGITS  active-low one-hot digit enable.
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0.
- pending  out  1  shadow holds a value not yet shown.

## Operation
- Registers: prescaler (0..REFRESH_DIV-1), digit index idx (0..NUM_DIGITS-1), shadow word, display word, pending flag.
- Prescaler counts every cycle and wraps at REFRESH_DIV-1. That wrap is the terminal count (tc).
- On tc, idx advances by 1. It wraps from NUM_DIGITS-1 to 0; that wrap is the frame wrap.
- load=1: shadow <= data_in, pending <= 1. Back-to-back loads overwrite; the last one wins.
- Frame wrap with pending=1: display <= shadow, pending <= 0.
- Frame wrap and load in the same cycle: display <= data_in directly, shadow <= data_in, pending stays 0.
- Display content changes only at a frame wrap.
- Leading-zero blanking, blank_lz=1: digit k is blanked iff all display nibbles k..NUM_DIGITS-1 are 0 and k≠0. Digit 0 is never blanked.
- blank_lz=0: no digit is blanked.
- blank_lz is sampled combinationally into the registered digit_blank at each tc.

## Timing
- All outputs are registered and update on the tc edge.
- At each tc the outputs take these values:
  - anode_n <= ~(1<<idx_next)
  - digit_nibble <= display_next nibble idx_next
  - digit_blank <= blank(idx_next)
- At the frame wrap, display_next is the newly swapped word, so digit 0 of a new frame already shows new data.
- frame_tick = 1 for exactly the cycle after the tc edge that wraps idx to 0.
- pending rises the cycle after load. It falls the cycle after the frame wrap that consumes it.
- Worst-case load-to-visible latency is NUM_DIGITS*REFRESH_DIV cycles.
- Reset values: prescaler 0, idx NUM_DIGITS-1, shadow 0, display 0, pending 0, anode_n all 1s, digit_nibble 0, digit_blank 1, frame_tick 0.
- The first tc after reset release occurs REFRESH_DIV cycles later and is a frame wrap: digit 0 is lit and frame_tick pulses.
- Reset mid-frame: all state returns to the reset values immediately (asynchronously) and any pending load is discarded.

## Structure
- Shared package hex_disp_pkg holds:
  - function clog2
  - localparams IDX_W = clog2(NUM_DIGITS) and PRESC_W = clog2(REFRESH_DIV)
  - constant SEG_OFF = 7'b1111111 for top-level blank muxing
- One sub-module, refresh_prescaler: parameter DIV; ports clk, rst_n, tc. It is reused by other scanned peripherals.
- Leading-zero logic is a combinational block inside the top module. The decoder is instantiated by the parent, not here.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- **Reset then idle:** release reset.
  - anode_n=4'b1111 for 4 cycles, then 4'b1110.
  - frame_tick pulses once.
  - digit_nibble=0, digit_blank=0, then blanks on digits 1–3 with blank_lz=1.
- **Load mid-frame:** load data_in=16'h12AB while idx=1.
  - pending=1 until the next wrap.
  - Digits 1–3 in the current frame still show old data.
  - The next frame shows B, A, 2, 1 on anodes 1110, 1101, 1011, 0111, each for 4 cycles.
- **Leading-zero blanking:** data 16'h0030 with blank_lz=1 gives digit_blank=0,0,1,1 for digits 0–3.
  - With blank_lz=0, all four digits are 0.
  - Data 16'h0000 shows digit 0 only.
- **Collisions:** load 16'h5555 then 16'hAAAA before the wrap, so only AAAA is displayed.
  - A load coinciding with the wrap cycle shows immediately at digit 0 and pending stays 0.
- **Async reset mid-frame:** assert rst_n=0 mid-frame with pending=1 and idx=2.
  - Outputs go to reset values without a clock edge.
  - After release, the display shows 0000 and pending=0.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for scanned display peripherals.
package hex_disp_pkg;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   localparam int DEF_NUM_DIGITS  = 4;
   localparam int DEF_REFRESH_DIV = 50000;
   localparam int IDX_W   = clog2(DEF_NUM_DIGITS);
   localparam int PRESC_W = clog2(DEF_REFRESH_DIV);

   // Segment pattern the parent drives when digit_blank is set (common anode).
   localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divide-by-DIV counter; tc is high in the last cycle of each period.
module refresh_prescaler
   import hex_disp_pkg::*;
#(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tc
);

   localparam int PW = clog2(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                 cnt <= cnt + PW'(1);
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed seven-segment scanner: double-buffered hex word, one digit lit per
// refresh period, optional leading-zero blanking.
module hex_display_scanner
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic                    blank_lz,
   output logic [3:0]              digit_nibble,
   output logic                    digit_blank,
   output logic [NUM_DIGITS-1:0]   anode_n,
   output logic                    frame_tick,
   output logic                    pending
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int IW = clog2(NUM_DIGITS);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic                  tc;
   logic                  wrap;
   logic [IW-1:0]         idx, idx_next;
   logic [W-1:0]          shadow, display, display_next;
   logic [NUM_DIGITS-1:0] blank_vec;

   refresh_prescaler #(.DIV(REFRESH_DIV)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .tc    (tc)
   );

   // A load landing on the wrap cycle bypasses the shadow so it is never a frame late.
   always_comb begin
      wrap         = tc && (idx == IDX_LAST);
      idx_next     = (idx == IDX_LAST) ? '0 : idx + IW'(1);
      display_next = display;
      if (wrap) begin
         if (load)         display_next = data_in;
         else if (pending) display_next = shadow;
      end
   end

   // Digit k is a leading zero when it and every digit above it are zero.
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
      if (k == 0) begin : g_d0
         assign blank_vec[k] = 1'b0;
      end else begin : g_dk
         assign blank_vec[k] = blank_lz & ~|display_next[W-1:4*k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= IDX_LAST;
         shadow       <= '0;
         display      <= '0;
         pending      <= 1'b0;
         anode_n      <= '1;
         digit_nibble <= '0;
         digit_blank  <= 1'b1;
         frame_tick   <= 1'b0;
      end else begin
         frame_tick <= wrap;
         if (load) shadow <= data_in;
         if (wrap)      pending <= 1'b0;
         else if (load) pending <= 1'b1;
         if (tc) begin
            idx          <= idx_next;
            display      <= display_next;
            anode_n      <= ~(NUM_DIGITS'(1) << idx_next);
            digit_nibble <= display_next[4*idx_next +: 4];
            digit_blank  <= blank_vec[idx_next];
         end
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scenario bench for hex_display_scanner with 4 digits and a 4-cycle refresh.
module tb_hex_display_scanner;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] data_in;
   logic        blank_lz;
   logic [3:0]  digit_nibble;
   logic        digit_blank;
   logic [3:0]  anode_n;
   logic        frame_tick;
   logic        pending;

   hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (load),
      .data_in      (data_in),
      .blank_lz     (blank_lz),
      .digit_nibble (digit_nibble),
      .digit_blank  (digit_blank),
      .anode_n      (anode_n),
      .frame_tick   (frame_tick),
      .pending      (pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] nib;
      logic       blk;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic void push_digit(input logic [15:0] w, input int k, input logic blz);
      exp_t e;
      logic [15:0] upper;
      upper  = w >> (4 * k);
      e.an   = ~(4'b0001 << k);
      e.nib  = upper[3:0];
      e.blk  = blz && (k != 0) && (upper == 16'h0);
      sb.push_back(e);
   endfunction

   function automatic void push_frame(input logic [15:0] w, input logic blz);
      for (int k = 0; k < 4; k++) push_digit(w, k, blz);
   endfunction

   // Waits (bounded) for the next digit switch; sits on a negedge on return.
   task automatic next_digit(output bit ok, output int cyc);
      logic [3:0] r;
      r   = anode_n;
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (anode_n !== r) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic seek(input logic [3:0] an, output bit ok);
      bit o;
      int c;
      ok = 1'b0;
      for (int i = 0; i < 6 && !ok; i++) begin
         next_digit(o, c);
         if (!o) break;
         if (anode_n === an) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      bit   ok;
      int   cyc;
      exp_t e;
      rst_n = 1'b0; load = 1'b0; data_in = '0; blank_lz = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({anode_n, digit_nibble, digit_blank, frame_tick, pending} !== {4'b1111, 4'h0, 1'b1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_vals: got an=%b nib=%h blk=%b ft=%b pend=%b want an=1111 nib=0 blk=1 ft=0 pend=0",
                  anode_n, digit_nibble, digit_blank, frame_tick, pending);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (anode_n !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_idle cyc%0d: got an=%b want 1111", i, anode_n);
         end
         if (i < 3) @(negedge clk);
      end
      next_digit(ok, cyc);
      n_cmp++;
      if (!ok || cyc != 1) begin
         n_err++;
         $display("FAIL first_tc: got ok=%0d cyc=%0d want ok=1 cyc=1", ok, cyc);
      end
      n_cmp++;
      if ({anode_n, digit_nibble, digit_blank, frame_tick} !== {4'b1110, 4'h0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL first_digit: got an=%b nib=%h blk=%b ft=%b want an=1110 nib=0 blk=0 ft=1",
                  anode_n, digit_nibble, digit_blank, frame_tick);
      end
      @(negedge clk);
      n_cmp++;
      if (frame_tick !== 1'b0) begin
         n_err++;
         $display("FAIL tick_width: got ft=%b want 0", frame_tick);
      end
      push_frame(16'h0000, 1'b1);
      void'(sb.pop_front());
      for (int i = 1; i < 4; i++) begin
         next_digit(ok, cyc);
         e = sb.pop_front();
         n_cmp++;
         if (!ok || {anode_n, digit_nibble, digit_blank} !== {e.an, e.nib, e.blk}) begin
            n_err++;
            $display("FAIL idle_frame d%0d: got ok=%0d an=%b nib=%h blk=%b want an=%b nib=%h blk=%b",
                     i, ok, anode_n, digit_nibble, digit_blank, e.an, e.nib, e.blk);
         end
      end
   endtask

   task automatic test_load_mid();
      bit   ok;
      int   cyc;
      exp_t e;
      seek(4'b1101, ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL load_mid_seek: got timeout want anode 1101");
      end
      load = 1'b1; data_in = 16'h12AB;
      @(negedge clk);
      load = 1'b0;
      n_cmp++;
      if (pending !== 1'b1) begin
         n_err++;
         $display("FAIL load_mid_pend: got %b want 1", pending);
      end
      push_digit(16'h0000, 2, 1'b1);
      push_digit(16'h0000, 3, 1'b1);
      push_frame(16'h12AB, 1'b1);
      for (int i = 0; i < 6; i++) begin
         next_digit(ok, cyc);
         e = sb.pop_front();
         n_cmp++;
         if (!ok || {anode_n, digit_nibble, digit_blank, pending} !== {e.an, e.nib, e.blk, (i < 2)}) begin
            n_err++;
            $display("FAIL load_mid step%0d: got ok=%0d an=%b nib=%h blk=%b pend=%b want an=%b nib=%h blk=%b pend=%b",
                     i, ok, anode_n, digit_nibble, digit_blank, pending, e.an, e.nib, e.blk, (i < 2));
         end
         if (i > 0) begin
            n_cmp++;
            if (cyc != 4) begin
               n_err++;
               $display("FAIL dwell step%0d: got %0d cycles want 4", i, cyc);
            end
         end
      end
   endtask

   task automatic test_leading_zero();
      bit   ok;
      int   cyc;
      exp_t e;
      logic [15:0] words [3];
      logic        blzs  [3];
      words[0] = 16'h0030; blzs[0] = 1'b1;
      words[1] = 16'h0030; blzs[1] = 1'b0;
      words[2] = 16'h0000; blzs[2] = 1'b1;
      for (int s = 0; s < 3; s++) begin
         blank_lz = blzs[s];
         if (s != 1) begin
            load = 1'b1; data_in = words[s];
            @(negedge clk);
            load = 1'b0;
         end
         seek(4'b1110, ok);
         push_frame(words[s], blzs[s]);
         for (int i = 0; i < 4; i++) begin
            if (i > 0) next_digit(ok, cyc);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || {anode_n, digit_nibble, digit_blank} !== {e.an, e.nib, e.blk}) begin
               n_err++;
               $display("FAIL lz s%0d d%0d: got ok=%0d an=%b nib=%h blk=%b want an=%b nib=%h blk=%b",
                        s, i, ok, anode_n, digit_nibble, digit_blank, e.an, e.nib, e.blk);
            end
         end
      end
   endtask

   task automatic test_collisions();
      bit   ok;
      int   cyc;
      exp_t e;
      load = 1'b1; data_in = 16'h5555;
      @(negedge clk);
      data_in = 16'hAAAA;
      @(negedge clk);
      load = 1'b0;
      n_cmp++;
      if (pending !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_pend: got %b want 1", pending);
      end
      seek(4'b1110, ok);
      push_frame(16'hAAAA, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) next_digit(ok, cyc);
         e = sb.pop_front();
         n_cmp++;
         if (!ok || {anode_n, digit_nibble, digit_blank, pending} !== {e.an, e.nib, e.blk, 1'b0}) begin
            n_err++;
            $display("FAIL b2b d%0d: got ok=%0d an=%b nib=%h blk=%b pend=%b want an=%b nib=%h blk=%b pend=0",
                     i, ok, anode_n, digit_nibble, digit_blank, pending, e.an, e.nib, e.blk);
         end
      end
      // Now on the first cycle of digit 3; the wrap cycle is three cycles on.
      repeat (3) @(negedge clk);
      load = 1'b1; data_in = 16'h9C3E;
      @(negedge clk);
      load = 1'b0;
      push_frame(16'h9C3E, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) next_digit(ok, cyc);
         e = sb.pop_front();
         n_cmp++;
         if (!ok || {anode_n, digit_nibble, digit_blank, pending} !== {e.an, e.nib, e.blk, 1'b0}) begin
            n_err++;
            $display("FAIL wrap_load d%0d: got ok=%0d an=%b nib=%h blk=%b pend=%b want an=%b nib=%h blk=%b pend=0",
                     i, ok, anode_n, digit_nibble, digit_blank, pending, e.an, e.nib, e.blk);
         end
         if (i == 0) begin
            n_cmp++;
            if (frame_tick !== 1'b1) begin
               n_err++;
               $display("FAIL wrap_load_tick: got ft=%b want 1", frame_tick);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      bit   ok;
      int   cyc;
      exp_t e;
      seek(4'b1011, ok);
      load = 1'b1; data_in = 16'h7777;
      @(negedge clk);
      load = 1'b0;
      n_cmp++;
      if (!ok || pending !== 1'b1) begin
         n_err++;
         $display("FAIL arst_setup: got ok=%0d pend=%b want ok=1 pend=1", ok, pending);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({anode_n, digit_nibble, digit_blank, frame_tick, pending} !== {4'b1111, 4'h0, 1'b1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL arst_vals: got an=%b nib=%h blk=%b ft=%b pend=%b want an=1111 nib=0 blk=1 ft=0 pend=0",
                  anode_n, digit_nibble, digit_blank, frame_tick, pending);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seek(4'b1110, ok);
      push_frame(16'h0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) next_digit(ok, cyc);
         e = sb.pop_front();
         n_cmp++;
         if (!ok || {anode_n, digit_nibble, digit_blank, pending} !== {e.an, e.nib, e.blk, 1'b0}) begin
            n_err++;
            $display("FAIL arst_frame d%0d: got ok=%0d an=%b nib=%h blk=%b pend=%b want an=%b nib=%h blk=%b pend=0",
                     i, ok, anode_n, digit_nibble, digit_blank, pending, e.an, e.nib, e.blk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_mid();
      test_leading_zero();
      test_collisions();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
